// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer
//  Description : SPI-style slave receiver. Shifts an instruction word in
//                MSB-first on mosi while cs_n is low, sampling on synchronized
//                spi_clk rising edges. Splits the word into opcode, key
//                address and text address, and hands it to the core over a
//                valid/ready handshake in the clk domain. Holds one completed
//                word while the consumer is busy. Any further words arriving
//                in that frame are dropped until cs_n goes high.
//  Ports       : clk, rst_n (async, active-low)
//                spi_clk, mosi, cs_n  - serial pins, asynchronous to clk
//                ready_in             - consumer can accept a word
//                opcode/key_addr/text_addr - word fields, valid with valid_out
//                valid_out            - one-cycle delivery strobe
//                overrun              - only with DESERIALIZER_OVERRUN_EN;
//                                       pulses on the first ignored bit of a
//                                       frame caused by a held word
//  Options     : `define DESERIALIZER_OVERRUN_EN adds the overrun output
//  Revision    : 1.0 - initial release
// ============================================================================
module deserializer #(
   parameter int ADDRW   = 8,
   parameter int OPCODEW = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               spi_clk,
   input  logic               mosi,
   input  logic               cs_n,
   input  logic               ready_in,
   output logic [OPCODEW-1:0] opcode,
   output logic [ADDRW-1:0]   key_addr,
   output logic [ADDRW-1:0]   text_addr,
   output logic               valid_out
`ifdef DESERIALIZER_OVERRUN_EN
   ,
   output logic               overrun
`endif
);

   localparam int SHIFT_W = OPCODEW + 2 * ADDRW;
   localparam int CNTW    = $clog2(SHIFT_W);
   localparam logic [CNTW-1:0] C_LAST_BIT = CNTW'(SHIFT_W - 1);

   // Two-flop synchronizers; spi_prev_q holds the prior synchronized sample
   // for edge detection.
   logic spi_s1_q, spi_s2_q, spi_prev_q;
   logic mosi_s1_q, mosi_s2_q;
   logic cs_s1_q, cs_s2_q;

   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [SHIFT_W-1:0] pend_q, pend_d;
   logic               pvalid_q, pvalid_d;
   logic               drop_q, drop_d;

   logic w_rise;
   logic w_deliver;

   assign w_rise    = spi_s2_q & ~spi_prev_q;
   assign w_deliver = pvalid_q & ready_in;

`ifdef DESERIALIZER_OVERRUN_EN
   logic ovr_d;
`endif

   always_comb begin
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      pvalid_d = pvalid_q;
      drop_d   = drop_q;
`ifdef DESERIALIZER_OVERRUN_EN
      ovr_d    = 1'b0;
`endif
      if (w_deliver) begin
         pvalid_d = 1'b0;
      end
      if (cs_s2_q) begin
         // Deselect: abandon any partial word and re-arm for the next frame.
         cnt_d   = '0;
         shift_d = '0;
         drop_d  = 1'b0;
      end else if (w_rise) begin
         if (pvalid_q || drop_q) begin
            // Once a bit is lost the frame is misaligned, so the rest of it
            // is discarded even if the held word drains meanwhile.
            drop_d = 1'b1;
`ifdef DESERIALIZER_OVERRUN_EN
            ovr_d  = pvalid_q & ~drop_q;
`endif
         end else begin
            shift_d = {shift_q[SHIFT_W-2:0], mosi_s2_q};
            if (cnt_q == C_LAST_BIT) begin
               // Capture only happens with pvalid_q low, so it never
               // collides with a delivery in the same cycle.
               pend_d   = shift_d;
               pvalid_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_s1_q   <= 1'b0;
         spi_s2_q   <= 1'b0;
         spi_prev_q <= 1'b0;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         shift_q    <= '0;
         cnt_q      <= '0;
         pend_q     <= '0;
         pvalid_q   <= 1'b0;
         drop_q     <= 1'b0;
         opcode     <= '0;
         key_addr   <= '0;
         text_addr  <= '0;
         valid_out  <= 1'b0;
`ifdef DESERIALIZER_OVERRUN_EN
         overrun    <= 1'b0;
`endif
      end else begin
         spi_s1_q   <= spi_clk;
         spi_s2_q   <= spi_s1_q;
         spi_prev_q <= spi_s2_q;
         mosi_s1_q  <= mosi;
         mosi_s2_q  <= mosi_s1_q;
         cs_s1_q    <= cs_n;
         cs_s2_q    <= cs_s1_q;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pvalid_q   <= pvalid_d;
         drop_q     <= drop_d;
         valid_out  <= w_deliver;
         // Fields only change on delivery so they hold after the strobe.
         if (w_deliver) begin
            opcode    <= pend_q[SHIFT_W-1 -: OPCODEW];
            key_addr  <= pend_q[SHIFT_W-OPCODEW-1 -: ADDRW];
            text_addr <= pend_q[ADDRW-1:0];
         end
`ifdef DESERIALIZER_OVERRUN_EN
         overrun    <= ovr_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deserializer
//  Description : Self-checking bench for deserializer. A frame-level model
//                tracks the held word and the drop state of each frame and
//                predicts the sequence of delivered words; observed strobes
//                are queued by a monitor and compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

   localparam int W = 18;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_clk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_n = 1'b1;
   logic       ready_in = 1'b0;
   logic [1:0] opcode;
   logic [7:0] key_addr;
   logic [7:0] text_addr;
   logic       valid_out;
`ifdef DESERIALIZER_OVERRUN_EN
   logic       overrun;
`endif

   deserializer #(.ADDRW(8), .OPCODEW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_clk   (spi_clk),
      .mosi      (mosi),
      .cs_n      (cs_n),
      .ready_in  (ready_in),
      .opcode    (opcode),
      .key_addr  (key_addr),
      .text_addr (text_addr),
      .valid_out (valid_out)
`ifdef DESERIALIZER_OVERRUN_EN
      ,
      .overrun   (overrun)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [W-1:0] obs_q[$];
   logic         prev_v = 1'b0;
   int           obs_ovr = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_out) begin
            obs_q.push_back({opcode, key_addr, text_addr});
            check_eq("no_back_to_back", 32'(prev_v), 32'd0);
         end
`ifdef DESERIALIZER_OVERRUN_EN
         if (overrun) obs_ovr++;
`endif
      end
      prev_v = valid_out;
   end

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q[$];
   bit           m_ready = 0;
   bit           m_pend  = 0;
   logic [W-1:0] m_pw;
   bit           m_drop  = 0;
   int           m_cnt   = 0;
   logic [W-1:0] m_acc   = '0;
   int           m_ovr   = 0;

   task automatic model_bit(input logic b);
      if (m_drop || m_pend) begin
         if (!m_drop) m_ovr++;
         m_drop = 1;
      end else begin
         m_acc = {m_acc[W-2:0], b};
         m_cnt++;
         if (m_cnt == W) begin
            m_cnt = 0;
            if (m_ready) exp_q.push_back(m_acc);
            else begin
               m_pend = 1;
               m_pw   = m_acc;
            end
         end
      end
   endtask

   task automatic model_frame_end();
      m_cnt  = 0;
      m_drop = 0;
   endtask

   task automatic set_ready(input bit v);
      @(negedge clk);
      ready_in = v;
      m_ready  = v;
      if (v && m_pend) begin
         exp_q.push_back(m_pw);
         m_pend = 0;
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic spi_bit(input logic b);
      spi_clk = 1'b0;
      mosi    = b;
      #30;
      spi_clk = 1'b1;
      #30;
      spi_clk = 1'b0;
      model_bit(b);
   endtask

   task automatic send_frame(input logic [2*W-1:0] data, input int n);
      cs_n = 1'b0;
      #60;
      for (int i = n - 1; i >= 0; i--) spi_bit(data[i]);
      #60;
      cs_n = 1'b1;
      model_frame_end();
      #120;
   endtask

   task automatic compare(input string tag);
      int n;
      #100;
      check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_eq({tag, "_word"}, 32'(obs_q[i]), 32'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   localparam logic [W-1:0] C_WA = {2'b01, 8'hAA, 8'h55};
   localparam logic [W-1:0] C_WB = {2'b10, 8'h0F, 8'hF0};
   localparam logic [W-1:0] C_WC = {2'b11, 8'h5A, 8'hC3};

   initial begin
      logic [2*W-1:0] d;
      int             nw, nb;
      bit             rdy;

      #23;
      check_eq("reset_opcode", 32'(opcode), 32'd0);
      check_eq("reset_key", 32'(key_addr), 32'd0);
      check_eq("reset_text", 32'(text_addr), 32'd0);
      check_eq("reset_valid", 32'(valid_out), 32'd0);
`ifdef DESERIALIZER_OVERRUN_EN
      check_eq("reset_overrun", 32'(overrun), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #50;

      // single word, consumer ready
      set_ready(1);
      send_frame({18'd0, C_WA}, W);
      compare("basic");

      // aborted partial frame, then a full one
      send_frame({18'd0, C_WB >> 9}, 9);
      compare("abort");
      send_frame({18'd0, C_WB}, W);
      compare("after_abort");

      // backpressure
      set_ready(0);
      send_frame({18'd0, C_WB}, W);
      #600;
      compare("held");
      set_ready(1);
      compare("released");

      // second frame discarded while a word is held
      set_ready(0);
      send_frame({18'd0, C_WC}, W);
      send_frame({18'd0, C_WA}, W);
      compare("overrun_held");
      set_ready(1);
      #300;
      compare("overrun_released");

      // back-to-back words in one frame
      send_frame({C_WA, C_WB}, 2 * W);
      compare("two_words");

      // randomized frames
      for (int it = 0; it < 10; it++) begin
         rdy = 1'($urandom_range(0, 1));
         set_ready(rdy);
         nw = $urandom_range(1, 2);
         d  = {18'($urandom), 18'($urandom)};
         nb = nw * W;
         if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, nw * W - 1);
         send_frame(d, nb);
         compare("rand_frame");
         set_ready(1);
         compare("rand_drain");
      end

      // reset in the middle of a frame
      cs_n = 1'b0;
      #60;
      for (int i = 0; i < 9; i++) spi_bit(1'b1);
      rst_n = 1'b0;
      #3;
      check_eq("midrst_opcode", 32'(opcode), 32'd0);
      check_eq("midrst_key", 32'(key_addr), 32'd0);
      check_eq("midrst_text", 32'(text_addr), 32'd0);
      check_eq("midrst_valid", 32'(valid_out), 32'd0);
      cs_n = 1'b1;
      m_pend = 0;
      model_frame_end();
      obs_q.delete();
      exp_q.delete();
      #50;
      @(negedge clk);
      rst_n = 1'b1;
      #50;
      send_frame({18'd0, C_WC}, W);
      compare("after_reset");

`ifdef DESERIALIZER_OVERRUN_EN
      check_eq("overrun_pulses", 32'(obs_ovr), 32'(m_ovr));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
- SPI-style slave receiver that shifts an instruction word in MSB-first on mosi, qualified by cs_n and sampled on spi_clk rising edges.
- Splits the word into opcode, key address and text address, then hands it to the core over a valid/ready style interface in the clk domain.
- Sits between the external SPI pins and the control-group command dispatcher.
- Holds one completed word while the consumer is not ready; extra incoming words are discarded until that word is delivered.

Parameters:
- ADDRW, 8, width of key_addr and text_addr.
- OPCODEW, 2, width of opcode.
- SHIFT_W (localparam), OPCODEW+2*ADDRW (18 by default), total bits per instruction word.

Ports:
- clk  in  1  core clock; all state is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  serial clock, asynchronous to clk; data sampled on its rising edge.
- mosi  in  1  serial data, MSB first.
- cs_n  in  1  active-low frame select, asynchronous to clk.
- ready_in  in  1  consumer may accept a word this cycle.
- opcode  out  OPCODEW  word[SHIFT_W-1 -: OPCODEW].
- key_addr  out  ADDRW  word[SHIFT_W-OPCODEW-1 -: ADDRW].
- text_addr  out  ADDRW  word[ADDRW-1:0].
- valid_out  out  1  one-cycle strobe; the fields are valid while it is high.

Behaviour:
- One clock domain (clk), asynchronous active-low reset rst_n.
- Reset values:
  - opcode, key_addr, text_addr and valid_out are 0.
  - Shift register, bit counter, pending word and pending_valid are cleared.
  - The drop flag is cleared and the synchronizers are reset (spi_clk and mosi to 0, cs_n to 1).
  - Reset asserted mid-frame abandons the frame immediately.
- spi_clk, mosi and cs_n each pass through a 2-flop synchronizer.
- A spi_clk rise is the synchronized spi_clk being 1 while its previous sample was 0 (one-cycle event).
- Interface constraints:
  - spi_clk high and low phases are each ≥3 clk periods.
  - mosi is stable ≥3 clk periods before each spi_clk rise.
- cs_n high (synchronized):
  - Bit counter is cleared, the partial shift contents are discarded and the drop flag is cleared.
  - An aborted frame never produces valid_out.
  - cs_n does not affect pending_valid.
- spi_clk rise with cs_n low, pending_valid=0 and drop=0:
  - shift = {shift[SHIFT_W-2:0], mosi_sync}; counter increments.
  - On the SHIFT_W-th bit the assembled word goes to the pending register in the same clk, pending_valid is set and the counter returns to 0.
  - Further words in the same frame are then accepted back-to-back.
- spi_clk rise with cs_n low and (pending_valid=1 or drop=1):
  - The bit is ignored and drop is set.
  - The rest of the frame is discarded until cs_n goes high, even if pending is consumed mid-frame.
- Output handshake, each clk:
  - If pending_valid and ready_in: next cycle valid_out=1, the fields load from the pending word, pending_valid clears. Otherwise valid_out=0.
  - valid_out is never high for two consecutive cycles.
  - Fields hold their last delivered value after valid_out drops.
- Latency: with ready_in=1, valid_out rises 2 clk after the clk in which the final spi_clk rise is detected.
- Backpressure: the pending word is held indefinitely with ready_in=0 and delivered exactly once after ready_in rises.
- Simultaneous capture of a new word and consumption of the old one cannot occur, because capture requires pending_valid=0.

Optional Feature:
- Macro DESERIALIZER_OVERRUN_EN.
- Defined:
  - Adds output port overrun (1 bit, reset 0).
  - overrun pulses high for one clk on the first ignored bit of a frame, i.e. when drop transitions 0→1 because pending_valid=1.
- Undefined: the port is absent and ignored bits are silently dropped.
- Core behaviour is identical either way.

Test Plan:
- ready_in=1; send {01,AA,55} with cs_n low, 60 ns spi_clk period, 100 MHz clk -> exactly one valid_out pulse with opcode=01, key_addr=AA, text_addr=55.
- Send the top 9 bits of {10,0F,F0}, then raise cs_n -> no valid_out. Then send the full word -> exactly one pulse with 10/0F/F0, proving the abort cleared the counter.
- ready_in=0; send {10,0F,F0}, wait 600 ns -> valid_out stays 0. Raise ready_in -> exactly one pulse with 10/0F/F0 and no repeats.
- ready_in=0; send {11,5A,C3}, then a second frame {01,AA,55} -> ignored (overrun pulse if enabled). Raise ready_in -> exactly one pulse with 11/5A/C3, and no second pulse afterwards.
- One 36-bit frame carrying {01,AA,55} then {10,0F,F0}, ready_in=1 -> two pulses in order with matching fields.
- Assert rst_n low mid-frame -> all outputs are 0. After release, a full word is received correctly.
